// File: rtl/cpri_unpack_sched_if.sv
// Request/grant and read-burst signals between the CPRI lane buffers, the
// unpack datapath and the scheduler that shares that datapath.
interface cpri_unpack_sched_if #(
    parameter int LANES = 4,
    parameter int AW    = 7
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic             i_enable;
    logic [LANES-1:0] i_req;
    logic             i_rready;
    logic [LANES-1:0] o_grant;
    logic [LW-1:0]    o_rd_lane;
    logic             o_rd_en;
    logic [AW-1:0]    o_rd_addr;
    logic             o_sof;
    logic             o_eof;
    logic [LANES-1:0] o_pkt_done;
    logic             o_sym_done;
    logic [LW-1:0]    o_sym_lane;
    logic             o_busy;
    logic             o_err;

    // The scheduler drives the burst; lanes and the datapath sit on the other side.
    modport master (
        input  i_enable, i_req, i_rready,
        output o_grant, o_rd_lane, o_rd_en, o_rd_addr, o_sof, o_eof,
               o_pkt_done, o_sym_done, o_sym_lane, o_busy, o_err
    );

    modport slave (
        output i_enable, i_req, i_rready,
        input  o_grant, o_rd_lane, o_rd_en, o_rd_addr, o_sof, o_eof,
               o_pkt_done, o_sym_done, o_sym_lane, o_busy, o_err
    );
endinterface

// File: rtl/cpri_unpack_sched.sv
// Round-robin scheduler sharing one CPRI IQ unpack datapath between lanes.
// Optional burst-stall watchdog enabled by defining SCHED_WDOG_EN.
module cpri_unpack_sched #(
    parameter int LANES       = 4,
    parameter int PKT_LEN     = 96,
    parameter int AW          = 7,
    parameter int GAP         = 2,
    parameter int PKT_PER_SYM = 33,
    parameter int WDOG_CYC    = 256
) (
    input  logic                i_clk,
    input  logic                i_reset,
    cpri_unpack_sched_if.master bus
);
    localparam int LW  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int IW  = LW + 1;
    localparam int GW  = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int SW  = (PKT_PER_SYM > 1) ? $clog2(PKT_PER_SYM) : 1;

    localparam logic [AW-1:0] LAST_ADDR = AW'(PKT_LEN - 1);
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [SW-1:0] SYM_LAST  = SW'(PKT_PER_SYM - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [LANES-1:0] grant_q, grant_d;
    logic [LW-1:0]    lane_q, lane_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [LW-1:0]    rr_q, rr_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [LANES-1:0] pkt_done_q, pkt_done_d;
    logic             sym_done_q, sym_done_d;
    logic [LW-1:0]    sym_lane_q, sym_lane_d;
    logic [SW-1:0]    sym_cnt_q [LANES];
    logic [SW-1:0]    sym_cnt_d [LANES];

    logic             rd_en;
    logic             end_burst;
    logic             count_pkt;
    logic             pick_found;
    logic [LW-1:0]    pick_lane;
    logic [IW-1:0]    pick_idx;

`ifdef SCHED_WDOG_EN
    localparam int STW = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
    localparam logic [STW-1:0] STALL_LAST = STW'(WDOG_CYC - 1);

    logic [STW-1:0]   stall_q, stall_d;
    logic             err_q, err_d;
`else
    logic             unused_wdog;
    assign unused_wdog = ^WDOG_CYC;
`endif

    assign rd_en = (state_q == S_BURST) && bus.i_rready;

    // First requesting lane at or after the round-robin pointer, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_lane  = '0;
        pick_idx   = '0;
        for (int i = 0; i < LANES; i++) begin
            pick_idx = {1'b0, rr_q} + IW'(i);
            if (pick_idx >= IW'(LANES)) pick_idx = pick_idx - IW'(LANES);
            if (!pick_found && bus.i_req[pick_idx[LW-1:0]]) begin
                pick_found = 1'b1;
                pick_lane  = pick_idx[LW-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        lane_d     = lane_q;
        addr_d     = addr_q;
        rr_d       = rr_q;
        gap_d      = gap_q;
        pkt_done_d = '0;
        sym_done_d = 1'b0;
        sym_lane_d = sym_lane_q;
        sym_cnt_d  = sym_cnt_q;
        end_burst  = 1'b0;
        count_pkt  = 1'b0;
`ifdef SCHED_WDOG_EN
        stall_d    = stall_q;
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.i_enable && pick_found) begin
                    state_d = S_BURST;
                    grant_d = LANES'(1) << pick_lane;
                    lane_d  = pick_lane;
                    addr_d  = '0;
                end
            end
            S_BURST: begin
                if (rd_en) begin
`ifdef SCHED_WDOG_EN
                    stall_d = '0;
`endif
                    if (addr_q == LAST_ADDR) begin
                        end_burst = 1'b1;
                        count_pkt = 1'b1;
                    end else begin
                        addr_d = addr_q + AW'(1);
                    end
                end
`ifdef SCHED_WDOG_EN
                // A stalled burst is dropped without counting toward the symbol.
                else if (stall_q == STALL_LAST) begin
                    end_burst = 1'b1;
                    err_d     = 1'b1;
                end else begin
                    stall_d = stall_q + STW'(1);
                end
`endif
                if (end_burst) begin
                    grant_d            = '0;
                    pkt_done_d[lane_q] = 1'b1;
                    rr_d               = (lane_q == LAST_LANE) ? '0 : lane_q + LW'(1);
                    addr_d             = '0;
                    gap_d              = '0;
                    state_d            = (GAP == 0) ? S_IDLE : S_GAP;
`ifdef SCHED_WDOG_EN
                    stall_d            = '0;
`endif
                end
                if (count_pkt) begin
                    if (sym_cnt_q[lane_q] == SYM_LAST) begin
                        sym_cnt_d[lane_q] = '0;
                        sym_done_d        = 1'b1;
                        sym_lane_d        = lane_q;
                    end else begin
                        sym_cnt_d[lane_q] = sym_cnt_q[lane_q] + SW'(1);
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            lane_q     <= '0;
            addr_q     <= '0;
            rr_q       <= '0;
            gap_q      <= '0;
            pkt_done_q <= '0;
            sym_done_q <= 1'b0;
            sym_lane_q <= '0;
            for (int k = 0; k < LANES; k++) sym_cnt_q[k] <= '0;
`ifdef SCHED_WDOG_EN
            stall_q    <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            lane_q     <= lane_d;
            addr_q     <= addr_d;
            rr_q       <= rr_d;
            gap_q      <= gap_d;
            pkt_done_q <= pkt_done_d;
            sym_done_q <= sym_done_d;
            sym_lane_q <= sym_lane_d;
            sym_cnt_q  <= sym_cnt_d;
`ifdef SCHED_WDOG_EN
            stall_q    <= stall_d;
            err_q      <= err_d;
`endif
        end
    end

    assign bus.o_grant    = grant_q;
    assign bus.o_rd_lane  = lane_q;
    assign bus.o_rd_en    = rd_en;
    assign bus.o_rd_addr  = addr_q;
    assign bus.o_sof      = rd_en && (addr_q == '0);
    assign bus.o_eof      = rd_en && (addr_q == LAST_ADDR);
    assign bus.o_pkt_done = pkt_done_q;
    assign bus.o_sym_done = sym_done_q;
    assign bus.o_sym_lane = sym_lane_q;
    assign bus.o_busy     = (state_q != S_IDLE);
`ifdef SCHED_WDOG_EN
    assign bus.o_err      = err_q;
`else
    assign bus.o_err      = 1'b0;
`endif
endmodule

// File: tb/tb_cpri_unpack_sched.sv
// Self-checking bench for cpri_unpack_sched: randomized backpressure and
// request patterns against a round-robin / per-lane packet-count model.
module tb_cpri_unpack_sched;
    localparam int LANES       = 4;
    localparam int PKT_LEN     = 96;
    localparam int AW          = 7;
    localparam int GAP         = 2;
    localparam int PKT_PER_SYM = 33;
    localparam int WDOG_CYC    = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   passCnt  = 0;
    int   totalCnt = 0;
    int   cycleCnt = 0;
    int   rrModel  = 0;

    int         obsWords, obsCycles, obsAddrErr, obsFlagErr;
    logic [3:0] obsDone, obsGrantAfter;
    logic       obsSym;
    logic [1:0] obsSymLane;

    cpri_unpack_sched_if #(.LANES(LANES), .AW(AW)) busIf();

    cpri_unpack_sched #(
        .LANES(LANES), .PKT_LEN(PKT_LEN), .AW(AW), .GAP(GAP),
        .PKT_PER_SYM(PKT_PER_SYM), .WDOG_CYC(WDOG_CYC)
    ) dut (
        .i_clk  (clk),
        .i_reset(reset),
        .bus    (busIf.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        busIf.i_enable = 1'b0;
        busIf.i_req    = '0;
        busIf.i_rready = 1'b0;
        tick();
        tick();
        reset   = 1'b0;
        rrModel = 0;
    endtask

    // Reference arbitration: first requester at or after the pointer, wrapping.
    function automatic int pick(input logic [3:0] r, input int p);
        for (int i = 0; i < LANES; i++) if (r[(p + i) % LANES]) return (p + i) % LANES;
        return -1;
    endfunction

    task automatic wait_grant(input int limit, output int waited);
        waited = 0;
        while (busIf.o_grant == '0 && waited < limit) begin
            tick();
            waited++;
        end
    endtask

    // Drives i_rready through one burst (0: always ready, 1: low every 4th, 2: random)
    // and records the observed read sequence plus the outputs of the following cycle.
    task automatic observe_burst(input int mode);
        obsWords = 0; obsCycles = 0; obsAddrErr = 0; obsFlagErr = 0;
        while (obsWords < PKT_LEN && obsCycles < 1000) begin
            case (mode)
                0:       busIf.i_rready = 1'b1;
                1:       busIf.i_rready = (obsCycles % 4 != 0);
                default: busIf.i_rready = ($urandom_range(0, 3) != 0);
            endcase
            #1;
            if (busIf.o_rd_en) begin
                if (busIf.o_rd_addr !== AW'(obsWords)) obsAddrErr++;
                if (busIf.o_sof !== (obsWords == 0)) obsFlagErr++;
                if (busIf.o_eof !== (obsWords == PKT_LEN - 1)) obsFlagErr++;
                obsWords++;
            end else if (busIf.o_sof || busIf.o_eof) begin
                obsFlagErr++;
            end
            obsCycles++;
            tick();
        end
        obsDone       = busIf.o_pkt_done;
        obsSym        = busIf.o_sym_done;
        obsSymLane    = busIf.o_sym_lane;
        obsGrantAfter = busIf.o_grant;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        busIf.i_enable = 1'b1; busIf.i_req = 4'hF; busIf.i_rready = 1'b1;
        tick(); tick(); #1;
        totalCnt++;
        if ({busIf.o_grant, busIf.o_pkt_done, busIf.o_rd_lane, busIf.o_sym_lane} !== 12'h0)
            $display("[TB] FAIL reset_vectors: got grant=%b done=%b lane=%0d symlane=%0d, expected all 0",
                     busIf.o_grant, busIf.o_pkt_done, busIf.o_rd_lane, busIf.o_sym_lane);
        else passCnt++;
        totalCnt++;
        if ({busIf.o_rd_en, busIf.o_sof, busIf.o_eof, busIf.o_sym_done, busIf.o_busy, busIf.o_err} !== 6'b0)
            $display("[TB] FAIL reset_flags: got rd_en=%b sof=%b eof=%b sym=%b busy=%b err=%b, expected 0",
                     busIf.o_rd_en, busIf.o_sof, busIf.o_eof, busIf.o_sym_done, busIf.o_busy, busIf.o_err);
        else passCnt++;
        totalCnt++;
        if (busIf.o_rd_addr !== 7'd0)
            $display("[TB] FAIL reset_addr: got %0d expected 0", busIf.o_rd_addr);
        else passCnt++;
    endtask

    task automatic test_single_lane();
        int waited, doneCycle;
        do_reset();
        busIf.i_enable = 1'b1; busIf.i_req = 4'b0100; busIf.i_rready = 1'b1;
        tick(); #1;
        totalCnt++;
        if (busIf.o_grant !== 4'b0100 || busIf.o_rd_lane !== 2'd2)
            $display("[TB] FAIL single_grant: got %b/%0d expected 0100/2", busIf.o_grant, busIf.o_rd_lane);
        else passCnt++;
        observe_burst(0);
        totalCnt++;
        if (obsWords != PKT_LEN || obsCycles != PKT_LEN || obsAddrErr != 0 || obsFlagErr != 0)
            $display("[TB] FAIL single_burst: got words=%0d cycles=%0d addrErr=%0d flagErr=%0d expected 96/96/0/0",
                     obsWords, obsCycles, obsAddrErr, obsFlagErr);
        else passCnt++;
        totalCnt++;
        if (obsDone !== 4'b0100 || obsGrantAfter !== 4'b0000)
            $display("[TB] FAIL single_done: got done=%b grant=%b expected 0100/0000", obsDone, obsGrantAfter);
        else passCnt++;
        doneCycle = cycleCnt;
        tick(); #1;
        totalCnt++;
        if (busIf.o_pkt_done !== 4'b0000 || busIf.o_busy !== 1'b1)
            $display("[TB] FAIL single_pulse: got done=%b busy=%b expected 0000/1", busIf.o_pkt_done, busIf.o_busy);
        else passCnt++;
        wait_grant(20, waited);
        totalCnt++;
        if (busIf.o_grant !== 4'b0100 || (cycleCnt - doneCycle) != GAP + 1)
            $display("[TB] FAIL single_regrant: got grant=%b after %0d cycles expected 0100 after %0d",
                     busIf.o_grant, cycleCnt - doneCycle, GAP + 1);
        else passCnt++;
    endtask

    task automatic test_round_robin();
        int waited, expLane, lastGrant;
        do_reset();
        busIf.i_enable = 1'b1; busIf.i_req = 4'hF; busIf.i_rready = 1'b1;
        lastGrant = 0;
        wait_grant(20, waited);
        for (int k = 0; k < 6; k++) begin
            expLane = pick(4'hF, rrModel);
            totalCnt++;
            if (busIf.o_grant !== (4'b1 << expLane) || busIf.o_rd_lane !== 2'(expLane))
                $display("[TB] FAIL rr_grant%0d: got %b expected lane %0d", k, busIf.o_grant, expLane);
            else passCnt++;
            if (k > 0) begin
                totalCnt++;
                if (cycleCnt - lastGrant != PKT_LEN + 1 + GAP)
                    $display("[TB] FAIL rr_spacing%0d: got %0d expected %0d", k, cycleCnt - lastGrant, PKT_LEN + 1 + GAP);
                else passCnt++;
            end
            lastGrant = cycleCnt;
            observe_burst(0);
            totalCnt++;
            if (obsDone !== (4'b1 << expLane) || obsAddrErr != 0)
                $display("[TB] FAIL rr_done%0d: got done=%b addrErr=%0d expected lane %0d", k, obsDone, obsAddrErr, expLane);
            else passCnt++;
            rrModel = (expLane + 1) % LANES;
            tick(); busIf.i_req[expLane] = 1'b0;
            tick(); busIf.i_req[expLane] = 1'b1;
            wait_grant(20, waited);
        end
    endtask

    task automatic test_backpressure();
        int waited;
        do_reset();
        busIf.i_enable = 1'b1; busIf.i_req = 4'b0010;
        wait_grant(20, waited);
        totalCnt++;
        if (busIf.o_grant !== 4'b0010)
            $display("[TB] FAIL bp_grant: got %b expected 0010", busIf.o_grant);
        else passCnt++;
        observe_burst(1);
        totalCnt++;
        if (obsCycles != 128 || obsWords != PKT_LEN || obsAddrErr != 0 || obsFlagErr != 0)
            $display("[TB] FAIL bp_burst: got cycles=%0d words=%0d addrErr=%0d flagErr=%0d expected 128/96/0/0",
                     obsCycles, obsWords, obsAddrErr, obsFlagErr);
        else passCnt++;
        totalCnt++;
        if (obsDone !== 4'b0010)
            $display("[TB] FAIL bp_done: got %b expected 0010", obsDone);
        else passCnt++;
        busIf.i_req = 4'b0000;
        tick(); #1;
        totalCnt++;
        if (busIf.o_pkt_done !== 4'b0000)
            $display("[TB] FAIL bp_once: got %b expected 0000", busIf.o_pkt_done);
        else passCnt++;
    endtask

    task automatic test_random_rr();
        int waited, expLane;
        do_reset();
        busIf.i_enable = 1'b1;
        busIf.i_req = 4'($urandom_range(1, 15));
        for (int k = 0; k < 8; k++) begin
            expLane = pick(busIf.i_req, rrModel);
            wait_grant(20, waited);
            totalCnt++;
            if (busIf.o_grant !== (4'b1 << expLane) || busIf.o_rd_lane !== 2'(expLane))
                $display("[TB] FAIL rand_grant%0d: got %b expected lane %0d", k, busIf.o_grant, expLane);
            else passCnt++;
            observe_burst(2);
            totalCnt++;
            if (obsWords != PKT_LEN || obsAddrErr != 0 || obsFlagErr != 0 || obsDone !== (4'b1 << expLane))
                $display("[TB] FAIL rand_burst%0d: got words=%0d addrErr=%0d flagErr=%0d done=%b expected lane %0d",
                         k, obsWords, obsAddrErr, obsFlagErr, obsDone, expLane);
            else passCnt++;
            rrModel = (expLane + 1) % LANES;
            tick();
            busIf.i_req = 4'($urandom_range(0, 15)) & ~(4'b1 << expLane);
            tick();
            if ($urandom_range(0, 1) == 1) busIf.i_req[expLane] = 1'b1;
            if (busIf.i_req == 4'b0000) busIf.i_req = 4'($urandom_range(1, 15));
        end
    endtask

    task automatic test_enable();
        int waited;
        do_reset();
        busIf.i_enable = 1'b0; busIf.i_req = 4'b0001; busIf.i_rready = 1'b1;
        repeat (8) tick();
        #1;
        totalCnt++;
        if (busIf.o_grant !== 4'b0000 || busIf.o_busy !== 1'b0)
            $display("[TB] FAIL en_block: got grant=%b busy=%b expected 0000/0", busIf.o_grant, busIf.o_busy);
        else passCnt++;
        busIf.i_enable = 1'b1;
        wait_grant(10, waited);
        totalCnt++;
        if (busIf.o_grant !== 4'b0001)
            $display("[TB] FAIL en_grant: got %b expected 0001", busIf.o_grant);
        else passCnt++;
        busIf.i_enable = 1'b0;
        observe_burst(0);
        totalCnt++;
        if (obsDone !== 4'b0001 || obsWords != PKT_LEN)
            $display("[TB] FAIL en_complete: got done=%b words=%0d expected 0001/96", obsDone, obsWords);
        else passCnt++;
        repeat (8) tick();
        #1;
        totalCnt++;
        if (busIf.o_grant !== 4'b0000 || busIf.o_busy !== 1'b0)
            $display("[TB] FAIL en_hold: got grant=%b busy=%b expected 0000/0", busIf.o_grant, busIf.o_busy);
        else passCnt++;
    endtask

    task automatic test_symbol();
        int waited, symModel;
        logic expSym;
        do_reset();
        busIf.i_enable = 1'b1; busIf.i_req = 4'b1000;
        symModel = 0;
        for (int p = 1; p <= PKT_PER_SYM + 1; p++) begin
            wait_grant(20, waited);
            totalCnt++;
            if (busIf.o_grant !== 4'b1000)
                $display("[TB] FAIL sym_grant%0d: got %b expected 1000", p, busIf.o_grant);
            else passCnt++;
            observe_burst(2);
            symModel++;
            expSym = (symModel == PKT_PER_SYM);
            if (expSym) symModel = 0;
            totalCnt++;
            if (obsDone !== 4'b1000 || obsSym !== expSym)
                $display("[TB] FAIL sym_pkt%0d: got done=%b sym=%b expected 1000/%b", p, obsDone, obsSym, expSym);
            else passCnt++;
            if (expSym) begin
                totalCnt++;
                if (obsSymLane !== 2'd3)
                    $display("[TB] FAIL sym_lane: got %0d expected 3", obsSymLane);
                else passCnt++;
            end
            tick(); busIf.i_req = 4'b0000;
            tick(); busIf.i_req = 4'b1000;
        end
        totalCnt++;
        if (busIf.o_sym_lane !== 2'd3 || busIf.o_sym_done !== 1'b0)
            $display("[TB] FAIL sym_hold: got lane=%0d sym=%b expected 3/0", busIf.o_sym_lane, busIf.o_sym_done);
        else passCnt++;
    endtask

    task automatic test_reset_mid_burst();
        int waited, guard;
        do_reset();
        busIf.i_enable = 1'b1; busIf.i_req = 4'b0100; busIf.i_rready = 1'b1;
        wait_grant(20, waited);
        #1;
        guard = 0;
        while (!(busIf.o_rd_en && busIf.o_rd_addr == 7'd40) && guard < 200) begin
            tick(); #1;
            guard++;
        end
        totalCnt++;
        if (busIf.o_rd_addr !== 7'd40 || busIf.o_grant !== 4'b0100)
            $display("[TB] FAIL mid_reach: got addr=%0d grant=%b expected 40/0100", busIf.o_rd_addr, busIf.o_grant);
        else passCnt++;
        reset = 1'b1;
        tick(); #1;
        totalCnt++;
        if ({busIf.o_grant, busIf.o_pkt_done, busIf.o_rd_en, busIf.o_busy, busIf.o_rd_lane} !== 12'h0 ||
            busIf.o_rd_addr !== 7'd0)
            $display("[TB] FAIL mid_abort: got grant=%b done=%b rd_en=%b busy=%b addr=%0d expected all 0",
                     busIf.o_grant, busIf.o_pkt_done, busIf.o_rd_en, busIf.o_busy, busIf.o_rd_addr);
        else passCnt++;
        reset = 1'b0; rrModel = 0;
        busIf.i_req = 4'b0110;
        wait_grant(20, waited);
        #1;
        totalCnt++;
        if (busIf.o_grant !== (4'b1 << pick(4'b0110, rrModel)) || busIf.o_rd_addr !== 7'd0 || busIf.o_sof !== 1'b1)
            $display("[TB] FAIL mid_regrant: got grant=%b addr=%0d sof=%b expected 0010/0/1",
                     busIf.o_grant, busIf.o_rd_addr, busIf.o_sof);
        else passCnt++;
    endtask

`ifdef SCHED_WDOG_EN
    task automatic test_wdog();
        int waited, stallCycles;
        do_reset();
        busIf.i_enable = 1'b1; busIf.i_req = 4'b0011; busIf.i_rready = 1'b0;
        wait_grant(20, waited);
        stallCycles = 0;
        while (busIf.o_pkt_done == 4'b0000 && stallCycles < 100) begin
            tick();
            stallCycles++;
        end
        totalCnt++;
        if (stallCycles != WDOG_CYC || busIf.o_pkt_done !== 4'b0001)
            $display("[TB] FAIL wdog_abort: got done=%b after %0d cycles expected 0001 after %0d",
                     busIf.o_pkt_done, stallCycles, WDOG_CYC);
        else passCnt++;
        totalCnt++;
        if (busIf.o_err !== 1'b1 || busIf.o_sym_done !== 1'b0 || busIf.o_grant !== 4'b0000)
            $display("[TB] FAIL wdog_flags: got err=%b sym=%b grant=%b expected 1/0/0000",
                     busIf.o_err, busIf.o_sym_done, busIf.o_grant);
        else passCnt++;
        rrModel = 1;
        tick(); busIf.i_req[0] = 1'b0;
        wait_grant(20, waited);
        totalCnt++;
        if (busIf.o_grant !== (4'b1 << pick(4'b0010, rrModel)) || busIf.o_err !== 1'b1)
            $display("[TB] FAIL wdog_next: got grant=%b err=%b expected 0010/1", busIf.o_grant, busIf.o_err);
        else passCnt++;
        observe_burst(0);
        totalCnt++;
        if (obsDone !== 4'b0010 || busIf.o_err !== 1'b1)
            $display("[TB] FAIL wdog_sticky: got done=%b err=%b expected 0010/1", obsDone, busIf.o_err);
        else passCnt++;
    endtask
`endif

    initial begin
        busIf.i_enable = 1'b0;
        busIf.i_req    = '0;
        busIf.i_rready = 1'b0;
        $display("[TB] starting cpri_unpack_sched bench");
        test_reset();
        test_single_lane();
        test_round_robin();
        test_backpressure();
        test_random_rr();
        test_enable();
        test_symbol();
        test_reset_mid_burst();
`ifdef SCHED_WDOG_EN
        test_wdog();
`endif
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule

// File: doc/cpri_unpack_sched.md
Name: cpri_unpack_sched

Overview:
Round-robin scheduler that shares one CPRI IQ unpack datapath between LANES CPRI receive lanes. Each lane buffers a complete CPRI packet and raises a request. The scheduler grants one lane per packet and drives the packet read burst (address 0..PKT_LEN-1) under downstream backpressure. It releases the lane's buffer when the burst ends and counts packets per lane to flag symbol completion.

Parameters:
LANES, 4, number of requesting CPRI lanes (2..8)
PKT_LEN, 96, words per CPRI packet (header + IQ + reserved)
AW, 7, read-address width; 2**AW >= PKT_LEN
GAP, 2, idle cycles forced between bursts (0 allowed)
PKT_PER_SYM, 33, packets per lane per OFDM symbol
WDOG_CYC, 256, stall limit in cycles; used only with the optional feature

Ports:
i_clk  in  1  single clock
i_reset  in  1  synchronous reset, active-high
i_enable  in  1  permits new grants
i_req  in  LANES  lane k holds one full packet
i_rready  in  1  unpack datapath accepts a word this cycle
o_grant  out  LANES  one-hot, held for the whole burst
o_rd_lane  out  $clog2(LANES)  index of the granted lane
o_rd_en  out  1  read strobe to the granted lane buffer
o_rd_addr  out  AW  read address
o_sof  out  1  high with o_rd_en when o_rd_addr==0
o_eof  out  1  high with o_rd_en when o_rd_addr==PKT_LEN-1
o_pkt_done  out  LANES  1-cycle pulse; frees the lane buffer
o_sym_done  out  1  1-cycle pulse; a lane completed PKT_PER_SYM packets
o_sym_lane  out  $clog2(LANES)  lane for o_sym_done
o_busy  out  1  state != IDLE
o_err  out  1  sticky watchdog error

Behaviour:
- Reset: all outputs 0, FSM=IDLE, RR pointer=0, every symbol counter=0, o_rd_addr=0. Reset applied mid-burst aborts the burst with no o_pkt_done pulse.
- FSM states: IDLE, BURST, GAP.
- IDLE: if i_enable and |i_req, select the first requesting lane at or after the RR pointer (wrapping). Register o_grant and o_rd_lane, set o_rd_addr=0, go to BURST. Grant is visible 1 cycle after the request is sampled.
- BURST:
  - o_rd_en = i_rready (combinational from i_rready; BURST-qualified).
  - Each cycle with o_rd_en, o_rd_addr increments. No address is skipped or repeated while stalled.
  - On o_rd_en with addr==PKT_LEN-1: next cycle o_grant clears, o_pkt_done[lane] pulses, RR pointer becomes lane+1 (mod LANES), o_rd_addr returns to 0. Next state is GAP, or IDLE if GAP==0.
- GAP: count GAP cycles, then go to IDLE. Arbitration runs only in IDLE, so the minimum request-to-request turnaround is GAP+1 cycles.
- i_req deasserting during BURST is ignored; the burst completes. i_req of the granted lane must stay high until o_pkt_done; the lane drops it the cycle after o_pkt_done.
- i_enable low blocks new grants only; an active burst completes.
- Symbol counter per lane, width $clog2(PKT_PER_SYM), increments on o_pkt_done[k].
  - When the counter is at PKT_PER_SYM-1 on o_pkt_done[k]: it wraps to 0, o_sym_done pulses in the same cycle as o_pkt_done, and o_sym_lane=k.
  - o_sym_lane holds its value otherwise.
- o_sof and o_eof are qualified by o_rd_en. For a 1-word packet (PKT_LEN==1), both assert together.
- o_busy is high in BURST and GAP.

Optional Feature:
SCHED_WDOG_EN
- Defined: a stall counter counts consecutive BURST cycles with i_rready low and clears on any o_rd_en. When it reaches WDOG_CYC, the burst is aborted:
  - o_pkt_done[lane] pulses, dropping the packet.
  - The symbol counter does not increment.
  - o_err is set (sticky until i_reset).
  - RR pointer advances; FSM goes to GAP.
- Undefined: no counter; the burst waits indefinitely for i_rready; o_err is tied to 0.

Test Plan:
1. Defaults; i_req=4'b0100 held, i_rready=1 -> o_grant=0100 one cycle later. Then 96 consecutive o_rd_en with addresses 0..95, o_sof at 0, o_eof at 95, o_pkt_done=0100 on the next cycle, 2 GAP cycles, then re-grant of lane 2.
2. After reset, i_req=4'b1111 held, lanes dropping req after o_pkt_done and re-raising -> grant order lane 0,1,2,3,0,1; bursts spaced 96+1+2 cycles apart.
3. Lane 1 burst with i_rready low every 4th cycle -> burst takes 128 cycles; o_rd_addr sequence 0..95 with no gaps or repeats; o_pkt_done[1] pulses once.
4. 33 packets from lane 3 -> o_sym_done=1 and o_sym_lane=3 together with the 33rd o_pkt_done[3]; the 34th packet produces no o_sym_done.
5. i_reset asserted while o_rd_addr=40 on lane 2 -> next cycle all outputs 0 and no o_pkt_done. With i_req=4'b0110 after release, lane 1 is granted at addr 0 (RR pointer=0).
6. SCHED_WDOG_EN with WDOG_CYC=16, i_rready held low in BURST -> after 16 stall cycles o_pkt_done pulses, o_err=1 and stays 1, the symbol counter is unchanged, and the next lane is granted after GAP.
